// File: rtl/output_port_arbiter.sv
// Output-port arbiter: round-robin grant among NIN input buffers into a
// single-entry registered output slot that drains and refills in one cycle.
module output_port_arbiter #(
    parameter int unsigned DW  = 64,
    parameter int unsigned NIN = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NIN-1:0] i_req,
    input  logic [DW-1:0]  i_din0,
    input  logic [DW-1:0]  i_din1,
    input  logic [DW-1:0]  i_din2,
    input  logic [DW-1:0]  i_din3,
    input  logic           i_ro,
    output logic [NIN-1:0] o_gnt,
    output logic [DW-1:0]  o_so,
    output logic           o_so_valid
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e        r_state, w_state_nxt;
    logic [1:0]    r_ptr, w_ptr_nxt;
    logic [DW-1:0] r_so, w_so_nxt;
    logic [1:0]    w_win, w_idx;
    logic          w_accept, w_grant;
    logic [DW-1:0] w_din_win;

    assign w_accept = (r_state == StEmpty) || i_ro;

    // Rotating search from r_ptr; reset masks all grants so no buffer is read.
    always_comb begin
        o_gnt   = '0;
        w_win   = 2'd0;
        w_idx   = 2'd0;
        w_grant = 1'b0;
        if (!reset && w_accept) begin
            for (int k = 0; k < 4; k++) begin
                w_idx = r_ptr + 2'(k);
                if (!w_grant && i_req[w_idx]) begin
                    o_gnt[w_idx] = 1'b1;
                    w_win        = w_idx;
                    w_grant      = 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (w_win)
            2'd0:    w_din_win = i_din0;
            2'd1:    w_din_win = i_din1;
            2'd2:    w_din_win = i_din2;
            default: w_din_win = i_din3;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_so_nxt    = r_so;
        if (w_grant) begin
            w_state_nxt = StFull;
            w_ptr_nxt   = w_win + 2'd1;
            w_so_nxt    = w_din_win;
        end else if (r_state == StFull && i_ro) begin
            // Drained with nothing to refill; payload is left stale.
            w_state_nxt = StEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StEmpty;
            r_ptr   <= 2'd0;
            r_so    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_so    <= w_so_nxt;
        end
    end

    assign o_so       = r_so;
    assign o_so_valid = (r_state == StFull);

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: directed vectors, an abstract slot/pointer
// model checked every cycle, plus literal expectations at key points.
module tb_output_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic        ro;
    logic [63:0] din [4];
    logic [3:0]  gnt;
    logic [63:0] so;
    logic        so_valid;

    int          n_total = 0;
    int          n_bad   = 0;
    bit          armed   = 1'b0;
    int          seq     = 0;

    // Model: slot occupancy, held payload, and round-robin start position.
    bit          m_full = 1'b0;
    logic [63:0] m_so   = '0;
    int          m_ptr  = 0;

    logic [63:0] exp_hold;

    always #5 clk = ~clk;

    output_port_arbiter #(.DW(64), .NIN(4)) dut (
        .clk        (clk),
        .reset      (rst),
        .i_req      (req),
        .i_din0     (din[0]),
        .i_din1     (din[1]),
        .i_din2     (din[2]),
        .i_din3     (din[3]),
        .i_ro       (ro),
        .o_gnt      (gnt),
        .o_so       (so),
        .o_so_valid (so_valid)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Winner index under current inputs, or -1 when nobody may be granted.
    function automatic int model_pick();
        if (rst || (m_full && !ro) || req == 4'b0) return -1;
        for (int k = 0; k < 4; k++)
            if (req[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] model_gnt();
        int w;
        w = model_pick();
        return (w < 0) ? 4'b0 : 4'(1 << w);
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            chk("gnt", {60'b0, gnt}, {60'b0, model_gnt()});
            chk("so_valid", {63'b0, so_valid}, {63'b0, m_full});
            chk("so", so, m_so);
        end
    end

    task automatic new_din();
        for (int i = 0; i < 4; i++) din[i] = {8'hD0, 8'(i), 16'h0, 32'(seq)};
        seq++;
    endtask

    task automatic cyc(input logic [3:0] rq, input logic r, input logic rs, input int xg);
        int w;
        req = rq;
        ro  = r;
        rst = rs;
        @(negedge clk);
        if (xg >= 0) chk("gnt_lit", {60'b0, gnt}, 64'(xg));
        @(posedge clk);
        w = model_pick();
        if (rs) begin
            m_full = 1'b0;
            m_so   = '0;
            m_ptr  = 0;
        end else if (w >= 0) begin
            m_so   = din[w];
            m_full = 1'b1;
            m_ptr  = (w + 1) % 4;
        end else if (m_full && ro) begin
            m_full = 1'b0;
        end
        #1;
    endtask

    localparam logic [3:0] TREQ [8] = '{4'h5, 4'hA, 4'h0, 4'hF, 4'h8, 4'h3, 4'h6, 4'h0};
    localparam logic       TRO  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        req = '0; ro = 1'b0; rst = 1'b1;
        new_din();
        #1;
        // Reset with everything requesting: no grant may leak out.
        cyc(4'hF, 1'b1, 1'b1, 0);
        armed = 1'b1;
        cyc(4'hF, 1'b1, 1'b1, 0);
        chk("rst_valid", {63'b0, so_valid}, 64'd0);
        chk("rst_so", so, 64'd0);

        // Single request under backpressure.
        din[0] = 64'hA5A5_0000_0000_0001;
        cyc(4'b0001, 1'b0, 1'b0, 1);
        chk("first_so", so, 64'hA5A5_0000_0000_0001);
        chk("first_valid", {63'b0, so_valid}, 64'd1);
        cyc(4'b0001, 1'b0, 1'b0, 0);
        cyc(4'b0000, 1'b1, 1'b0, 0);

        // Full rotation from ptr=0 at one packet per cycle.
        cyc(4'h0, 1'b0, 1'b1, 0);
        for (int k = 0; k < 5; k++) begin
            new_din();
            cyc(4'hF, 1'b1, 1'b0, 1 << (k % 4));
            chk("rot_so", so, din[k % 4]);
            chk("rot_valid", {63'b0, so_valid}, 64'd1);
        end

        // Wrap-around: grant 1 leaves ptr=2, then req=0011 must pick input 0.
        new_din();
        cyc(4'hF, 1'b1, 1'b0, 2);
        new_din();
        cyc(4'b0011, 1'b1, 1'b0, 1);
        exp_hold = din[0];

        // Backpressure holds the slot; release drains and refills together.
        for (int k = 0; k < 3; k++) begin
            new_din();
            cyc(4'b0100, 1'b0, 1'b0, 0);
            chk("hold_so", so, exp_hold);
        end
        new_din();
        cyc(4'b0100, 1'b1, 1'b0, 4);
        chk("refill_so", so, din[2]);
        chk("refill_valid", {63'b0, so_valid}, 64'd1);

        // Drain with no request, then ro toggling while empty.
        cyc(4'b0000, 1'b1, 1'b0, 0);
        chk("drain_valid", {63'b0, so_valid}, 64'd0);
        for (int k = 0; k < 4; k++) cyc(4'b0000, 1'(k % 2), 1'b0, 0);
        chk("idle_valid", {63'b0, so_valid}, 64'd0);

        // Reset while full with ptr=3 discards the packet; restart at input 0.
        new_din();
        cyc(4'b0100, 1'b1, 1'b0, 4);
        cyc(4'hF, 1'b1, 1'b1, 0);
        chk("rst2_valid", {63'b0, so_valid}, 64'd0);
        chk("rst2_so", so, 64'd0);
        new_din();
        cyc(4'hF, 1'b1, 1'b0, 1);

        // Mixed patterns checked by the model only.
        for (int k = 0; k < 8; k++) begin
            new_din();
            cyc(TREQ[k], TRO[k], 1'b0, -1);
        end

        armed = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/output_port_arbiter.md
OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 Parameter: DW, 64, flit/packet data width per input and output.
REQ-002 Parameter: NIN, 4, number of input channel buffers competing for this output port; fixed at 4 for this release.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  NIN  per-input request; bit i high means input channel buffer i is full and its packet routes to this port.
REQ-006 din0..din3  input  DW each  held packet data of input channel buffers 0..3.
REQ-007 ro  input  1  downstream ready; high means the downstream consumer takes the held packet this cycle.
REQ-008 gnt  output  NIN  one-hot grant, combinational; drives the granted input buffer's read enable (RE).
REQ-009 so  output  DW  registered output packet.
REQ-010 so_valid  output  1  registered; high while so holds an unconsumed packet.

Function
REQ-011 Output slot SHALL be a 2-state FSM: EMPTY (so_valid=0) and FULL (so_valid=1).
REQ-012 "accept" SHALL be defined as (state==EMPTY) or (state==FULL and ro==1).
REQ-013 gnt SHALL be all-zero when accept==0 or req==0.
REQ-014 When accept==1 and req!=0, gnt SHALL have exactly one bit set: the first requesting input at or after priority pointer ptr, searching ptr, ptr+1, ... modulo 4.
REQ-015 ptr SHALL be a 2-bit register; on any cycle with a grant to input w, ptr SHALL become (w+1) mod 4 on the next edge; otherwise it SHALL hold.
REQ-016 On a grant to input w, so SHALL load din_w on the same edge and state SHALL be FULL next cycle (1-cycle latency from grant to so_valid).
REQ-017 FULL with ro==1 and no grant: state SHALL go to EMPTY; so SHALL hold its old value (don't-care contents, not cleared).
REQ-018 FULL with ro==1 and a grant (simultaneous drain and refill): state SHALL remain FULL and so SHALL load the new packet, giving one packet per cycle sustained throughput.
REQ-019 FULL with ro==0: state, so and ptr SHALL hold; gnt SHALL be zero (backpressure).
REQ-020 EMPTY with req==0: state SHALL stay EMPTY; ro is ignored while EMPTY.
REQ-021 Requests that lose arbitration SHALL receive no grant and SHALL NOT be dropped; they stay pending (their buffers remain full) until granted.
REQ-022 A single continuously requesting input SHALL be granted every accept cycle; with all four requesting and ro held high, grants SHALL rotate 0,1,2,3,0,... from ptr=0.
REQ-023 gnt SHALL depend only on req, ptr, state and ro; it SHALL NOT depend on din.
REQ-024 A packet SHALL be presented on so for at least one cycle and SHALL be counted as consumed only on a cycle with so_valid==1 and ro==1.

Reset
REQ-025 While reset is high on a clock edge: state SHALL become EMPTY, so_valid 0, so all-zero, ptr 0.
REQ-026 While reset is high, gnt SHALL be all-zero regardless of req/ro, so no input buffer is read during reset.
REQ-027 Reset asserted while FULL SHALL discard the held packet; first grant after reset release SHALL follow REQ-014 with ptr=0.

Verification
REQ-028 Reset then req=0001, din0=0xA5A5_0000_0000_0001, ro=0 -> gnt=0001 one cycle; next cycle so=din0, so_valid=1, gnt=0000 while ro=0.
REQ-029 req=1111 held, ro=1 every cycle from ptr=0 -> gnt sequence 0001,0010,0100,1000,0001; so_valid stays 1 after the first load; so tracks din of each winner one cycle later.
REQ-030 ptr=2 (after grant to input 1), req=0011 -> gnt=0001 (wrap-around from 2 past 3 to 0); ptr becomes 1.
REQ-031 FULL, ro=0 for 3 cycles with req=0100 -> gnt=0000, so unchanged for 3 cycles; ro=1 on 4th -> gnt=0100 that cycle, so=din2 next cycle, so_valid stays 1.
REQ-032 FULL, ro=1, req=0000 -> so_valid=0 next cycle; subsequent ro toggling with req=0000 -> no state change.
REQ-033 FULL with ptr=3, assert reset one cycle with req=1111 -> gnt=0000 during reset; after release so_valid=0 then first grant 0001.
